// File: rtl/seq_dispatcher_if.sv
// Purpose: host command, sequencer handshake and response bundle for seq_dispatcher.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready on the command side; responses are unthrottled pulses.
// Ports: master = dispatcher side (drives cmd_ready, start/seq/ext_sync, busy, rsp_*, counters);
//        slave  = host + sequencer side (drives cmd_*, running, done).
interface seq_dispatcher_if #(
    parameter int DLY_W = 8
);
    // host command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_seq;
    logic [DLY_W-1:0] cmd_sync_dly;

    // sequencer handshake
    logic             start;
    logic             seq;
    logic             ext_sync;
    logic             running;
    logic             done;

    // status and response
    logic             busy;
    logic             rsp_valid;
    logic             rsp_seq;
    logic             rsp_timeout;
    logic [7:0]       done_cnt;
    logic [7:0]       tmo_cnt;

    modport master (
        input  cmd_valid, cmd_seq, cmd_sync_dly, running, done,
        output cmd_ready, start, seq, ext_sync, busy,
               rsp_valid, rsp_seq, rsp_timeout, done_cnt, tmo_cnt
    );

    modport slave (
        output cmd_valid, cmd_seq, cmd_sync_dly, running, done,
        input  cmd_ready, start, seq, ext_sync, busy,
               rsp_valid, rsp_seq, rsp_timeout, done_cnt, tmo_cnt
    );
endinterface

// File: rtl/seq_dispatcher.sv
// Purpose: queues host sequence commands and runs them one at a time against a sequencer.
// Latency: accept at edge k -> start high k+1..k+2, first ACTIVE cycle k+2..k+3; one IDLE cycle between commands.
// Backpressure: cmd_ready low while the command FIFO is full; rsp_valid is a pulse with no backpressure.
// Ports: clk, reset_n (synchronous, active-low), bus (seq_dispatcher_if.master).
module seq_dispatcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int DLY_W      = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    seq_dispatcher_if.master bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT);
    // ACTIVE counter is wide enough for both the timeout index and any delay value,
    // so a delay beyond the timeout simply never matches.
    localparam int CW = ((DLY_W > TW) ? DLY_W : TW) + 1;

    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] ACT_ONE   = CW'(1);
    localparam logic [CW-1:0] ACT_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_ACTIVE,
        S_REPORT
    } state_t;

    state_t           r_state;

    // command FIFO
    logic             r_fifo_seq [FIFO_DEPTH];
    logic [DLY_W-1:0] r_fifo_dly [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_cmd_ready;

    // current command and outputs
    logic             r_seq;
    logic [DLY_W-1:0] r_dly;
    logic [CW-1:0]    r_act_cnt;
    logic             r_start;
    logic             r_ext_sync;
    logic             r_busy;
    logic             r_rsp_valid;
    logic             r_rsp_seq;
    logic             r_rsp_timeout;
    logic [7:0]       r_done_cnt;
    logic [7:0]       r_tmo_cnt;

    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_count_nxt;
    logic [CW-1:0]    w_act_nxt;
    logic [CW-1:0]    w_dly_ext;
    logic             w_unused_running;

    assign w_push    = bus.cmd_valid & r_cmd_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_act_nxt = r_act_cnt + ACT_ONE;
    assign w_dly_ext = {{(CW-DLY_W){1'b0}}, r_dly};

    // running is status only; nothing in the control path depends on it
    assign w_unused_running = bus.running;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    // FIFO storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_seq[r_wr_ptr] <= bus.cmd_seq;
            r_fifo_dly[r_wr_ptr] <= bus.cmd_sync_dly;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_cmd_ready   <= 1'b1;
            r_seq         <= 1'b0;
            r_dly         <= '0;
            r_act_cnt     <= '0;
            r_start       <= 1'b0;
            r_ext_sync    <= 1'b0;
            r_busy        <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_seq     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_done_cnt    <= '0;
            r_tmo_cnt     <= '0;
        end else begin
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt != FIFO_FULL);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end

            // single-cycle pulses default low
            r_start     <= 1'b0;
            r_ext_sync  <= 1'b0;
            r_rsp_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_seq   <= r_fifo_seq[r_rd_ptr];
                        r_dly   <= r_fifo_dly[r_rd_ptr];
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    r_act_cnt  <= '0;
                    // outputs are registered, so the sync for ACTIVE cycle 0 is decided here
                    r_ext_sync <= r_seq && (w_dly_ext == '0);
                    r_state    <= S_ACTIVE;
                end

                S_ACTIVE: begin
                    if (bus.done) begin
                        // done has priority over a timeout landing in the same cycle
                        r_rsp_valid   <= 1'b1;
                        r_rsp_seq     <= r_seq;
                        r_rsp_timeout <= 1'b0;
                        r_done_cnt    <= r_done_cnt + 8'd1;
                        r_state       <= S_REPORT;
                    end else if (r_act_cnt == ACT_LAST) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_seq     <= r_seq;
                        r_rsp_timeout <= 1'b1;
                        r_tmo_cnt     <= r_tmo_cnt + 8'd1;
                        r_state       <= S_REPORT;
                    end else begin
                        r_act_cnt  <= w_act_nxt;
                        r_ext_sync <= r_seq && (w_act_nxt == w_dly_ext);
                    end
                end

                S_REPORT: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.start       = r_start;
    assign bus.seq         = r_seq;
    assign bus.ext_sync    = r_ext_sync;
    assign bus.busy        = r_busy;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_seq     = r_rsp_seq;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.done_cnt    = r_done_cnt;
    assign bus.tmo_cnt     = r_tmo_cnt;
endmodule

// File: tb/tb_seq_dispatcher.sv
// Purpose: self-checking bench for seq_dispatcher with a behavioural sequencer and response scoreboard.
// Latency: checks start one cycle after accept, ext_sync at its ACTIVE index, response one cycle after done/timeout.
// Backpressure: fills the command FIFO while a command is stalled and checks cmd_ready drops.
module tb_seq_dispatcher;
    localparam int FIFO_DEPTH = 4;
    localparam int DLY_W      = 8;
    localparam int TIMEOUT    = 64;

    // done_at: ACTIVE index where the sequencer raises done (-1 = never)
    // exp_sync: ACTIVE index where ext_sync must pulse (-1 = never)
    typedef struct {
        logic             seq;
        logic [DLY_W-1:0] dly;
        int               done_at;
        int               exp_sync;
        logic             exp_tmo;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int   n_vec = 0;
    int   n_err = 0;

    vec_t       cmd_q [$];
    vec_t       cur;
    int         act = -1;
    bit         rsp_due = 1'b0;
    bit         busy_due = 1'b0;
    logic [7:0] exp_done_cnt = 8'd0;
    logic [7:0] exp_tmo_cnt  = 8'd0;

    seq_dispatcher_if #(.DLY_W(DLY_W)) bus ();

    seq_dispatcher #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DLY_W      (DLY_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endfunction

    // Sequencer model + scoreboard: pops the expected command on start, drives done,
    // and checks ext_sync / response / counters against the popped record.
    initial begin : monitor
        bit started;
        bit exp_sync;
        bus.done    = 1'b0;
        bus.running = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                act          = -1;
                rsp_due      = 1'b0;
                busy_due     = 1'b0;
                cmd_q.delete();
                exp_done_cnt = 8'd0;
                exp_tmo_cnt  = 8'd0;
                bus.done     = 1'b0;
                bus.running  = 1'b0;
            end else begin
                started = 1'b0;
                if (bus.start) begin
                    if (act >= 0 || rsp_due || cmd_q.size() == 0) begin
                        chk("start_unexpected", 32'(bus.start), 0);
                    end else begin
                        cur     = cmd_q.pop_front();
                        started = 1'b1;
                        chk("start_seq", 32'(bus.seq), 32'(cur.seq));
                    end
                end
                if (act >= 0) begin
                    chk("seq_hold", 32'(bus.seq), 32'(cur.seq));
                    chk("busy_active", 32'(bus.busy), 1);
                end
                exp_sync = (act >= 0) && (act == cur.exp_sync);
                if (exp_sync || bus.ext_sync) begin
                    chk("ext_sync", 32'(bus.ext_sync), 32'(exp_sync));
                end
                if (busy_due) begin
                    chk("busy_after_rsp", 32'(bus.busy), 0);
                end
                busy_due = 1'b0;
                if (rsp_due || bus.rsp_valid) begin
                    chk("rsp_valid", 32'(bus.rsp_valid), 32'(rsp_due));
                    if (rsp_due) begin
                        if (cur.exp_tmo) exp_tmo_cnt++;
                        else             exp_done_cnt++;
                        chk("rsp_seq", 32'(bus.rsp_seq), 32'(cur.seq));
                        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(cur.exp_tmo));
                        chk("done_cnt", 32'(bus.done_cnt), 32'(exp_done_cnt));
                        chk("tmo_cnt", 32'(bus.tmo_cnt), 32'(exp_tmo_cnt));
                        busy_due = 1'b1;
                    end
                end
                rsp_due = 1'b0;
                if (act >= 0) begin
                    bus.done    = (act == cur.done_at);
                    bus.running = 1'b1;
                    if (act == cur.done_at || act == TIMEOUT - 1) begin
                        rsp_due = 1'b1;
                        act     = -1;
                    end else begin
                        act++;
                    end
                end else begin
                    // stray done/running outside ACTIVE must be ignored
                    bus.done    = ($urandom_range(0, 3) == 0);
                    bus.running = 1'($urandom_range(0, 1));
                end
                if (started) act = 0;
            end
        end
    end

    task automatic send_cmd(input vec_t v, input int max_wait);
        int w = 0;
        bus.cmd_valid    = 1'b1;
        bus.cmd_seq      = v.seq;
        bus.cmd_sync_dly = v.dly;
        while (bus.cmd_ready !== 1'b1 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            chk("cmd_accept_wait", 32'(bus.cmd_ready), 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        cmd_q.push_back(v);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((bus.busy || cmd_q.size() != 0 || rsp_due) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait_budget", 32'(n < lim), 1);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs [10];
        vec_t burst [5];
        vec_t q0;
        vec_t stall;
        vec_t longc;
        int   n;

        //             seq   dly     done  sync  tmo
        vecs[0] = '{1'b0, 8'd0,   10,   -1,  1'b0}; // plain done, no sync
        vecs[1] = '{1'b1, 8'd5,   6,    5,   1'b0}; // sync at 5, done right after
        vecs[2] = '{1'b1, 8'd20,  -1,   20,  1'b1}; // never done -> timeout
        vecs[3] = '{1'b1, 8'd0,   63,   0,   1'b0}; // done on last cycle beats timeout
        vecs[4] = '{1'b0, 8'd7,   -1,   -1,  1'b1}; // seq=0 timeout, no sync
        vecs[5] = '{1'b1, 8'd63,  -1,   63,  1'b1}; // sync on final ACTIVE cycle
        vecs[6] = '{1'b1, 8'd200, 3,    -1,  1'b0}; // delay beyond window
        vecs[7] = '{1'b1, 8'd9,   4,    -1,  1'b0}; // done before sync point
        vecs[8] = '{1'b0, 8'd0,   0,    -1,  1'b0}; // done in first ACTIVE cycle
        vecs[9] = '{1'b1, 8'd3,   3,    3,   1'b0}; // sync and done together

        burst[0] = '{1'b0, 8'd0, 1, -1, 1'b0};
        burst[1] = '{1'b1, 8'd1, 2, 1,  1'b0};
        burst[2] = '{1'b0, 8'd4, 0, -1, 1'b0};
        burst[3] = '{1'b1, 8'd0, 5, 0,  1'b0};
        burst[4] = '{1'b1, 8'd2, 3, 2,  1'b0};
        q0       = '{1'b0, 8'd0, 0, -1, 1'b0};
        stall    = '{1'b1, 8'd2, 40, 2, 1'b0};
        longc    = '{1'b1, 8'd30, -1, 30, 1'b1};

        bus.cmd_valid    = 1'b0;
        bus.cmd_seq      = 1'b0;
        bus.cmd_sync_dly = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_start", 32'(bus.start), 0);
        chk("rst_seq", 32'(bus.seq), 0);
        chk("rst_ext_sync", 32'(bus.ext_sync), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_seq", 32'(bus.rsp_seq), 0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 0);
        chk("rst_done_cnt", 32'(bus.done_cnt), 0);
        chk("rst_tmo_cnt", 32'(bus.tmo_cnt), 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // single commands from idle, with start latency checked on each
        for (int i = 0; i < 10; i++) begin
            send_cmd(vecs[i], 20);
            chk("lat_no_start_yet", 32'(bus.start), 0);
            @(negedge clk);
            chk("lat_start", 32'(bus.start), 1);
            chk("lat_busy", 32'(bus.busy), 1);
            wait_idle(200);
        end

        // FIFO fills behind a stalled command; order is kept
        send_cmd(stall, 20);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) send_cmd(burst[i], 20);
        chk("cmd_ready_full", 32'(bus.cmd_ready), 0);
        send_cmd(burst[4], 200);
        wait_idle(400);
        chk("cmd_ready_drained", 32'(bus.cmd_ready), 1);

        // one-cycle reset while ACTIVE with commands still queued
        send_cmd(longc, 20);
        send_cmd(q0, 20);
        send_cmd(q0, 20);
        n = 0;
        while (act < 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_active", 32'(act >= 10), 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("mid_rst_done_cnt", 32'(bus.done_cnt), 0);
        chk("mid_rst_tmo_cnt", 32'(bus.tmo_cnt), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mid_rst_fifo_empty", 32'(bus.busy), 0);
        end

        // 256 completions wrap done_cnt back to 0
        for (int i = 0; i < 256; i++) send_cmd(q0, 50);
        wait_idle(200);
        chk("done_cnt_wrap", 32'(bus.done_cnt), 0);
        chk("tmo_cnt_after_wrap", 32'(bus.tmo_cnt), 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
